// File: rtl/uart_tx_sb_ctrl.sv
// Bus-mapped UART transmitter: start bit, 8 data bits LSB first, optional even parity, 1 or 2 stop bits.
// Defining UART_TX_FIFO_EN adds a 4-entry byte FIFO ahead of the serialiser.
module uart_tx_sb_ctrl #(
  parameter int unsigned CLK_FREQ     = 10_000_000,
  parameter int unsigned DEFAULT_BAUD = 9600
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        write_enable_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] write_data_i,
  output logic [31:0] read_data_o,
  output logic        tx_o
);

  localparam logic [23:0] ADDR_DATA = 24'h00_0000;
  localparam logic [23:0] ADDR_BUSY = 24'h00_0008;
  localparam logic [23:0] ADDR_BAUD = 24'h00_000C;
  localparam logic [23:0] ADDR_PAR  = 24'h00_0010;
  localparam logic [23:0] ADDR_STOP = 24'h00_0014;
  localparam logic [23:0] ADDR_RST  = 24'h00_0024;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  function automatic logic baud_ok(input logic [31:0] baud);
    case (baud)
      32'd9600, 32'd19200, 32'd38400, 32'd57600, 32'd115200: baud_ok = 1'b1;
      default: baud_ok = 1'b0;
    endcase
  endfunction

  function automatic logic [15:0] baud_div(input logic [31:0] baud);
    case (baud)
      32'd9600:   baud_div = 16'(CLK_FREQ / 32'd9600);
      32'd19200:  baud_div = 16'(CLK_FREQ / 32'd19200);
      32'd38400:  baud_div = 16'(CLK_FREQ / 32'd38400);
      32'd57600:  baud_div = 16'(CLK_FREQ / 32'd57600);
      32'd115200: baud_div = 16'(CLK_FREQ / 32'd115200);
      default:    baud_div = 16'(CLK_FREQ / DEFAULT_BAUD);
    endcase
  endfunction

  function automatic logic even_par(input logic [7:0] data);
    even_par = ^data;
  endfunction

  state_t      state_r, state_s;
  logic [15:0] cnt_r, div_s;
  logic [2:0]  bit_idx_r;
  logic        stop_idx_r, frame_par_r, frame_two_stop_r;
  logic [7:0]  data_r, start_data_s;
  logic        tx_r, tx_s;
  logic [31:0] baud_r, read_data_r, rd_mux_s;
  logic        parity_r;
  logic [1:0]  stop_r;
  logic [23:0] off_s;
  logic        wr_s, rd_s, srst_s, data_wr_s;
  logic        bit_done_s, frame_end_s, start_s, busy_s, cfg_lock_s;
  logic        unused_s;

  assign off_s       = addr_i[23:0];
  assign unused_s    = ^addr_i[31:24];
  assign wr_s        = req_i & write_enable_i;
  assign rd_s        = req_i & ~write_enable_i;
  assign srst_s      = wr_s && (off_s == ADDR_RST) && write_data_i[0];
  assign data_wr_s   = wr_s && (off_s == ADDR_DATA);
  assign div_s       = baud_div(baud_r);
  assign bit_done_s  = (cnt_r == (div_s - 16'd1));
  assign frame_end_s = (state_r == STOP) && bit_done_s && (stop_idx_r == frame_two_stop_r);

`ifdef UART_TX_FIFO_EN
  logic [7:0] fifo_r [4];
  logic [1:0] wr_ptr_r, rd_ptr_r;
  logic [2:0] count_r;
  logic       push_s, pop_s;

  // The head entry stays in the FIFO while its frame is on the line.
  assign push_s       = data_wr_s && (count_r != 3'd4);
  assign pop_s        = frame_end_s;
  assign start_s      = ((state_r == IDLE) && (count_r != 3'd0)) || (frame_end_s && (count_r > 3'd1));
  assign start_data_s = (state_r == IDLE) ? fifo_r[rd_ptr_r] : fifo_r[rd_ptr_r + 2'd1];
  assign busy_s       = (count_r == 3'd4);
  assign cfg_lock_s   = (state_r != IDLE) || (count_r != 3'd0);

  // FIFO storage
  always_ff @(posedge clk_i) begin
    if (push_s) begin
      fifo_r[wr_ptr_r] <= write_data_i[7:0];
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_r <= 2'd0;
      rd_ptr_r <= 2'd0;
      count_r  <= 3'd0;
    end else if (srst_s) begin
      wr_ptr_r <= 2'd0;
      rd_ptr_r <= 2'd0;
      count_r  <= 3'd0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + 2'd1;
      if (pop_s)  rd_ptr_r <= rd_ptr_r + 2'd1;
      count_r <= count_r + {2'd0, push_s} - {2'd0, pop_s};
    end
  end
`else
  assign start_s      = data_wr_s && ((state_r == IDLE) || frame_end_s);
  assign start_data_s = write_data_i[7:0];
  assign busy_s       = (state_r != IDLE);
  assign cfg_lock_s   = (state_r != IDLE);
`endif

  // Next state and serial bit for the state being left
  always_comb begin
    state_s = state_r;
    tx_s    = 1'b1;
    case (state_r)
      IDLE: begin
        tx_s = 1'b1;
        if (start_s) state_s = START;
        else         state_s = IDLE;
      end
      START: begin
        tx_s = 1'b0;
        if (bit_done_s) state_s = DATA;
        else            state_s = START;
      end
      DATA: begin
        tx_s = data_r[bit_idx_r];
        if (bit_done_s && (bit_idx_r == 3'd7)) state_s = frame_par_r ? PARITY : STOP;
        else                                    state_s = DATA;
      end
      PARITY: begin
        tx_s = even_par(data_r);
        if (bit_done_s) state_s = STOP;
        else            state_s = PARITY;
      end
      STOP: begin
        tx_s = 1'b1;
        if (frame_end_s) state_s = start_s ? START : IDLE;
        else             state_s = STOP;
      end
      default: begin
        tx_s    = 1'b1;
        state_s = IDLE;
      end
    endcase
  end

  // Read mux; write-only and unmapped offsets return zero
  always_comb begin
    rd_mux_s = 32'd0;
    case (off_s)
      ADDR_BUSY: rd_mux_s = {31'd0, busy_s};
      ADDR_BAUD: rd_mux_s = baud_r;
      ADDR_PAR:  rd_mux_s = {31'd0, parity_r};
      ADDR_STOP: rd_mux_s = {30'd0, stop_r};
      default:   rd_mux_s = 32'd0;
    endcase
  end

  // Frame sequencing, configuration registers and bus read data
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r          <= IDLE;
      cnt_r            <= 16'd0;
      bit_idx_r        <= 3'd0;
      stop_idx_r       <= 1'b0;
      frame_par_r      <= 1'b0;
      frame_two_stop_r <= 1'b0;
      data_r           <= 8'd0;
      tx_r             <= 1'b1;
      baud_r           <= 32'(DEFAULT_BAUD);
      parity_r         <= 1'b1;
      stop_r           <= 2'd1;
      read_data_r      <= 32'd0;
    end else if (srst_s) begin
      state_r          <= IDLE;
      cnt_r            <= 16'd0;
      bit_idx_r        <= 3'd0;
      stop_idx_r       <= 1'b0;
      frame_par_r      <= 1'b0;
      frame_two_stop_r <= 1'b0;
      data_r           <= 8'd0;
      tx_r             <= 1'b1;
      baud_r           <= 32'(DEFAULT_BAUD);
      parity_r         <= 1'b1;
      stop_r           <= 2'd1;
      read_data_r      <= 32'd0;
    end else begin
      state_r <= state_s;
      tx_r    <= tx_s;
      if ((state_r == IDLE) || bit_done_s) cnt_r <= 16'd0;
      else                                 cnt_r <= cnt_r + 16'd1;

      if (start_s) begin
        data_r           <= start_data_s;
        frame_par_r      <= parity_r;
        frame_two_stop_r <= (stop_r == 2'd2);
        bit_idx_r        <= 3'd0;
        stop_idx_r       <= 1'b0;
      end else begin
        if ((state_r == DATA) && bit_done_s) bit_idx_r <= bit_idx_r + 3'd1;
        if ((state_r == STOP) && bit_done_s && !frame_end_s) stop_idx_r <= 1'b1;
      end

      // Config is frozen while anything is queued or on the line
      if (wr_s && !cfg_lock_s) begin
        case (off_s)
          ADDR_BAUD: if (baud_ok(write_data_i)) baud_r <= write_data_i;
          ADDR_PAR:  parity_r <= write_data_i[0];
          ADDR_STOP: if ((write_data_i == 32'd1) || (write_data_i == 32'd2)) stop_r <= write_data_i[1:0];
          default:   ;
        endcase
      end

      if (rd_s) read_data_r <= rd_mux_s;
    end
  end

  assign read_data_o = read_data_r;
  assign tx_o        = tx_r;

endmodule

// File: tb/tb_uart_tx_sb_ctrl.sv
// Directed self-checking bench for uart_tx_sb_ctrl at 10 MHz / 115200 baud (86 clocks per bit).
module tb_uart_tx_sb_ctrl;

  logic        clk, rst, req, we;
  logic [31:0] addr, wd, rd_data;
  logic        tx;
  int          checks   = 0;
  int          failures = 0;

  uart_tx_sb_ctrl #(.CLK_FREQ(10_000_000), .DEFAULT_BAUD(9600)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .write_enable_i(we),
    .addr_i(addr), .write_data_i(wd), .read_data_o(rd_data), .tx_o(tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = a; wd = d;
    @(posedge clk); #1;
    req = 1'b0; we = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = a;
    @(posedge clk); #1;
    req = 1'b0;
    d = rd_data;
  endtask

  // Sends byte b and samples tx mid-bit; optional bus write injected at cycle inj_c.
  task automatic run_frame(input logic [7:0] b, input int nbits, input logic [11:0] exp_bits,
                           input int flen, input int inj_c, input logic [31:0] inj_a,
                           input logic [31:0] inj_d, input logic exp_busy_after, input string tag);
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 32'h0; wd = {24'd0, b};
    @(posedge clk); #1;
    req = 1'b0; we = 1'b0;
    checks++;
    if (tx !== 1'b1) begin
      failures++; $display("FAIL %s_pre_start: tx=%b expected 1", tag, tx);
    end
    for (int c = 1; c <= flen + 1; c++) begin
      @(negedge clk);
      if (c == inj_c) begin
        req = 1'b1; we = 1'b1; addr = inj_a; wd = inj_d;
      end else if (c >= flen) begin
        req = 1'b1; we = 1'b0; addr = 32'h08;
      end
      @(posedge clk); #1;
      req = 1'b0; we = 1'b0;
      if (((c % 86) == 43) && ((c / 86) < nbits)) begin
        checks++;
        if (tx !== exp_bits[c / 86]) begin
          failures++; $display("FAIL %s_bit%0d: tx=%b expected %b", tag, c / 86, tx, exp_bits[c / 86]);
        end
      end
      if ((c == flen) && (c != inj_c)) begin
        checks++;
        if (rd_data !== 32'd1) begin
          failures++; $display("FAIL %s_busy_last: got %0d expected 1", tag, rd_data);
        end
      end
      if (c == flen + 1) begin
        checks++;
        if (rd_data !== {31'd0, exp_busy_after}) begin
          failures++; $display("FAIL %s_busy_after: got %0d expected %0d", tag, rd_data, exp_busy_after);
        end
        checks++;
        if (tx !== ~exp_busy_after) begin
          failures++; $display("FAIL %s_tx_after: tx=%b expected %b", tag, tx, ~exp_busy_after);
        end
      end
    end
  endtask

  task automatic test_reset();
    logic [31:0] v;
    rst = 1'b1; req = 1'b0; we = 1'b0; addr = 32'h0; wd = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (tx !== 1'b1) begin failures++; $display("FAIL reset_tx: tx=%b expected 1", tx); end
    checks++;
    if (rd_data !== 32'd0) begin failures++; $display("FAIL reset_rdata: got %0d expected 0", rd_data); end
    @(negedge clk); rst = 1'b0;
    bus_read(32'h0C, v);
    checks++;
    if (v !== 32'd9600) begin failures++; $display("FAIL reset_baud: got %0d expected 9600", v); end
    bus_read(32'h08, v);
    checks++;
    if (v !== 32'd0) begin failures++; $display("FAIL reset_busy: got %0d expected 0", v); end
    bus_read(32'h10, v);
    checks++;
    if (v !== 32'd1) begin failures++; $display("FAIL reset_parity: got %0d expected 1", v); end
    bus_read(32'h14, v);
    checks++;
    if (v !== 32'd1) begin failures++; $display("FAIL reset_stop: got %0d expected 1", v); end
  endtask

  task automatic test_config();
    logic [31:0] v;
    bus_write(32'h0C, 32'd115200);
    bus_read(32'h0C, v);
    checks++;
    if (v !== 32'd115200) begin failures++; $display("FAIL cfg_baud: got %0d expected 115200", v); end
    bus_write(32'h0C, 32'd12345);
    bus_read(32'h0C, v);
    checks++;
    if (v !== 32'd115200) begin failures++; $display("FAIL cfg_bad_baud: got %0d expected 115200", v); end
    bus_write(32'h14, 32'd3);
    bus_read(32'h14, v);
    checks++;
    if (v !== 32'd1) begin failures++; $display("FAIL cfg_bad_stop: got %0d expected 1", v); end
    bus_write(32'h14, 32'd2);
    bus_read(32'h14, v);
    checks++;
    if (v !== 32'd2) begin failures++; $display("FAIL cfg_stop2: got %0d expected 2", v); end
    bus_write(32'h20, 32'hFFFF_FFFF);
    bus_read(32'h20, v);
    checks++;
    if (v !== 32'd0) begin failures++; $display("FAIL cfg_unmapped: got %0d expected 0", v); end
    bus_read(32'h00, v);
    checks++;
    if (v !== 32'd0) begin failures++; $display("FAIL cfg_wo_read: got %0d expected 0", v); end
    bus_write(32'h10, 32'd0);
    bus_write(32'h14, 32'd1);
    bus_read(32'h10, v);
    checks++;
    if (v !== 32'd0) begin failures++; $display("FAIL cfg_parity0: got %0d expected 0", v); end
  endtask

  task automatic test_frame_basic();
    run_frame(8'h55, 10, 12'h2AA, 860, -1, 32'h0, 32'h0, 1'b0, "f55");
  endtask

  task automatic test_parity_two_stop();
    bus_write(32'h10, 32'd1);
    bus_write(32'h14, 32'd2);
    run_frame(8'h07, 12, 12'hE0E, 1032, -1, 32'h0, 32'h0, 1'b0, "f07");
    bus_write(32'h10, 32'd0);
    bus_write(32'h14, 32'd1);
  endtask

  task automatic test_busy_writes();
    logic [31:0] v;
    run_frame(8'h3C, 10, 12'h278, 860, 200, 32'h00, 32'hAA, 1'b0, "drop");
    run_frame(8'h55, 10, 12'h2AA, 860, 300, 32'h10, 32'h1, 1'b0, "lock");
    bus_read(32'h10, v);
    checks++;
    if (v !== 32'd0) begin failures++; $display("FAIL lock_parity: got %0d expected 0", v); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] v;
    int n;
    run_frame(8'h55, 10, 12'h2AA, 860, 860, 32'h00, 32'h0F, 1'b1, "b2b");
    n = 0;
    v = 32'd1;
    while ((v == 32'd1) && (n < 3000)) begin
      bus_read(32'h08, v);
      if (v == 32'd1) n++;
    end
    checks++;
    if (n != 859) begin failures++; $display("FAIL b2b_second_len: busy reads=%0d expected 859", n); end
  endtask

  task automatic test_soft_reset();
    logic [31:0] v;
    bus_write(32'h10, 32'd0);
    bus_write(32'h14, 32'd2);
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 32'h0; wd = 32'h0;
    @(posedge clk); #1;
    req = 1'b0; we = 1'b0;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      if (c == 100) begin req = 1'b1; we = 1'b0; addr = 32'h0C; end
      if (c == 300) begin req = 1'b1; we = 1'b1; addr = 32'h24; wd = 32'd1; end
      @(posedge clk); #1;
      req = 1'b0; we = 1'b0;
      if (c == 100) begin
        checks++;
        if (rd_data !== 32'd115200) begin failures++; $display("FAIL srst_pre_read: got %0d expected 115200", rd_data); end
      end
      if (c == 299) begin
        checks++;
        if (tx !== 1'b0) begin failures++; $display("FAIL srst_midframe: tx=%b expected 0", tx); end
      end
    end
    checks++;
    if (tx !== 1'b1) begin failures++; $display("FAIL srst_tx: tx=%b expected 1", tx); end
    checks++;
    if (rd_data !== 32'd0) begin failures++; $display("FAIL srst_rdata: got %0d expected 0", rd_data); end
    bus_read(32'h08, v);
    checks++;
    if (v !== 32'd0) begin failures++; $display("FAIL srst_busy: got %0d expected 0", v); end
    bus_read(32'h0C, v);
    checks++;
    if (v !== 32'd9600) begin failures++; $display("FAIL srst_baud: got %0d expected 9600", v); end
    bus_read(32'h10, v);
    checks++;
    if (v !== 32'd1) begin failures++; $display("FAIL srst_parity: got %0d expected 1", v); end
    bus_read(32'h14, v);
    checks++;
    if (v !== 32'd1) begin failures++; $display("FAIL srst_stop: got %0d expected 1", v); end
    repeat (100) @(posedge clk);
    #1;
    checks++;
    if (tx !== 1'b1) begin failures++; $display("FAIL srst_idle: tx=%b expected 1", tx); end
  endtask

`ifdef UART_TX_FIFO_EN
  task automatic test_fifo();
    logic [7:0] bytes [5];
    logic       eb;
    int         c;
    bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33; bytes[3] = 8'h44; bytes[4] = 8'h55;
    bus_write(32'h0C, 32'd115200);
    bus_write(32'h10, 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      req = 1'b1; we = 1'b1; addr = 32'h0; wd = {24'd0, bytes[i]};
      @(posedge clk); #1;
    end
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 32'h08;
    @(posedge clk); #1;
    req = 1'b0;
    checks++;
    if (rd_data !== 32'd1) begin failures++; $display("FAIL fifo_full: got %0d expected 1", rd_data); end
    c = 5;
    while (c < 1 + 4 * 860 + 43) begin
      @(posedge clk); #1;
      c++;
      if ((((c - 1) % 86) == 43) && (c < 1 + 4 * 860)) begin
        int j, k;
        j = (c - 1) / 860;
        k = ((c - 1) % 860) / 86;
        if (k == 0)      eb = 1'b0;
        else if (k <= 8) eb = bytes[j][k - 1];
        else             eb = 1'b1;
        checks++;
        if (tx !== eb) begin failures++; $display("FAIL fifo_f%0d_bit%0d: tx=%b expected %b", j, k, tx, eb); end
      end
    end
    checks++;
    if (tx !== 1'b1) begin failures++; $display("FAIL fifo_fifth_dropped: tx=%b expected 1", tx); end
  endtask
`endif

  initial begin
    test_reset();
    test_config();
`ifdef UART_TX_FIFO_EN
    test_fifo();
`else
    test_frame_basic();
    test_parity_two_stop();
    test_busy_writes();
    test_back_to_back();
`endif
    test_soft_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
